// File: rtl/vertex_xform_sched.sv
// Sequencer for the shared 4x4 matrix_mult: credit-limited vertex issue, in-order result FIFO,
// and a double-buffered transform matrix that is only swapped once the multiplier has drained.
module vertex_xform_sched #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] ONE        = 32'h0001_0000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          cfg_we_in,
  input  logic [3:0]    cfg_addr_in,
  input  logic [31:0]   cfg_data_in,
  input  logic          cfg_commit_in,
  input  logic          vtx_valid_in,
  output logic          vtx_ready_out,
  input  logic [127:0]  vtx_data_in,
  output logic          mm_valid_out,
  output logic [511:0]  mm_mat_out,
  output logic [127:0]  mm_vec_out,
  input  logic          mm_valid_in,
  input  logic [127:0]  mm_result_in,
  output logic          res_valid_out,
  input  logic          res_ready_in,
  output logic [127:0]  res_data_out,
  output logic          busy_out,
  output logic          err_out,
  output logic [15:0]   vtx_count_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWAP} state_t;

  state_t          r_state, w_next_state;
  logic            r_pending, w_next_pending;
  logic [511:0]    r_active, r_shadow;
  logic [CW-1:0]   r_inflight;
  logic            r_mm_valid;
  logic [127:0]    r_mm_vec;
  logic [127:0]    r_mem [FIFO_DEPTH];
  logic [CW-1:0]   r_wr_ptr, r_rd_ptr;
  logic            r_err;
  logic [15:0]     r_count;

  logic [CW-1:0]   w_fifo_count;
  logic [CW:0]     w_credit_used;
  logic            w_empty, w_full, w_vtx_ready, w_vtx_hs;
  logic            w_spurious, w_push, w_pop, w_swap;

  function automatic logic [511:0] identity_mat();
    logic [511:0] m;
    m = '0;
    for (int r = 0; r < 4; r++) m[r*160 +: 32] = ONE;
    return m;
  endfunction

  // Outstanding work is everything issued but not yet popped; that bounds the FIFO.
  assign w_fifo_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign w_vtx_ready   = (r_state == S_RUN) && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign w_vtx_hs      = vtx_valid_in && w_vtx_ready;
  assign w_spurious    = mm_valid_in && (r_inflight == '0);
  assign w_push        = mm_valid_in && !w_spurious;
  assign w_pop         = !w_empty && res_ready_in;
  assign w_swap        = (r_state == S_SWAP);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_RUN;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_next_pending;
    end
  end

  // Commits seen outside RUN are absorbed: the drain already in progress will pick up the shadow.
  always_comb begin
    w_next_state   = r_state;
    w_next_pending = r_pending;
    case (r_state)
      S_RUN: begin
        if (cfg_commit_in || r_pending) begin
          w_next_state   = S_DRAIN;
          w_next_pending = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((r_inflight == '0) && !r_mm_valid) w_next_state = S_SWAP;
      end
      S_SWAP: begin
        w_next_state   = S_RUN;
        w_next_pending = 1'b0;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_active <= identity_mat();
      r_shadow <= identity_mat();
    end else begin
      if (w_swap) r_active <= r_shadow;
      if (cfg_we_in) r_shadow[{cfg_addr_in, 5'd0} +: 32] <= cfg_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mm_valid <= 1'b0;
      r_mm_vec   <= '0;
      r_inflight <= '0;
    end else begin
      r_mm_valid <= w_vtx_hs;
      if (w_vtx_hs) r_mm_vec <= vtx_data_in;
      case ({w_vtx_hs, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= mm_result_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
        r_count  <= r_count + 16'd1;
      end
      if (w_spurious) r_err <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(w_push && w_full && !w_pop));

  assign vtx_ready_out = w_vtx_ready;
  assign mm_valid_out  = r_mm_valid;
  assign mm_vec_out    = r_mm_vec;
  assign mm_mat_out    = r_active;
  assign res_valid_out = !w_empty;
  assign res_data_out  = r_mem[r_rd_ptr[AW-1:0]];
  assign busy_out      = (r_state != S_RUN) || (r_inflight != '0) || !w_empty;
  assign err_out       = r_err;
  assign vtx_count_out = r_count;

endmodule

// File: doc/vertex_xform_sched.md
Name: vertex_xform_sched

Overview:
- Sequencer for the shared 4x4 by 4x1 matrix_mult datapath in the 3D pipeline.
- Holds the active transform matrix and a shadow copy that software or the UI loads word by word.
- Streams incoming vertices into matrix_mult and collects the transformed vertices in order into a result FIFO.
- Swaps in a new matrix only when the multiplier is fully drained, so no vertex is ever transformed by a mix of old and new coefficients.

Parameters:
- FIFO_DEPTH, 8: result FIFO entries; also the credit limit on outstanding vertices. Must be a power of two, ≥2.
- ONE, 32'h0001_0000: diagonal value of the reset identity matrix. Coefficients are opaque 32-bit words.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- cfg_we_in  input  1  shadow matrix write strobe
- cfg_addr_in  input  4  shadow element index, row*4+col
- cfg_data_in  input  32  shadow element value
- cfg_commit_in  input  1  pulse: request shadow→active swap
- vtx_valid_in  input  1  vertex stream valid
- vtx_ready_out  output  1  vertex stream ready
- vtx_data_in  input  128  vertex {w,z,y,x}, x in [31:0]
- mm_valid_out  output  1  issue pulse to matrix_mult valid_in
- mm_mat_out  output  512  active matrix, element r*4+c at bits [(r*4+c)*32 +: 32]
- mm_vec_out  output  128  issued vertex
- mm_valid_in  input  1  matrix_mult valid_out
- mm_result_in  input  128  matrix_mult mat_out, packed as for vtx_data_in
- res_valid_out  output  1  result stream valid
- res_ready_in  input  1  result stream ready
- res_data_out  output  128  transformed vertex
- busy_out  output  1  high when state≠RUN, or inflight≠0, or FIFO non-empty
- err_out  output  1  sticky: a result arrived with inflight==0
- vtx_count_out  output  16  completed results popped, wraps at 65535→0

Behaviour:
- Reset: one clock; rst_in is asynchronous and active-high.
- Reset values:
  - Active and shadow matrices = identity (ONE on the diagonal, 0 elsewhere).
  - State RUN; inflight=0; FIFO empty; commit pending cleared.
  - Outputs: mm_valid_out=0, mm_vec_out=0, res_valid_out=0, err_out=0, vtx_count_out=0, busy_out=0.
  - Reset mid-operation discards in-flight results. Any mm_valid_in that arrives after reset release with inflight==0 sets err_out.
- Credit and ready:
  - vtx_ready_out = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH). It is combinational from registers only, not from vtx_valid_in.
- Issue:
  - A vtx handshake in cycle N drives mm_vec_out ← vtx_data_in at N+1.
  - mm_valid_out is high for exactly cycle N+1; inflight increments.
  - Back-to-back handshakes give back-to-back issue pulses.
- Completion:
  - mm_valid_in pushes mm_result_in into the FIFO and decrements inflight.
  - Simultaneous issue and completion leave inflight unchanged.
  - mm_valid_in with inflight==0: the result is dropped and err_out is set.
  - The FIFO cannot overflow because of the credit rule. An overflow is an assertion failure.
- Result FIFO:
  - First-word fall-through: res_valid_out = !empty, res_data_out = head entry.
  - Pop on res_valid_out && res_ready_in; vtx_count_out increments on each pop.
  - Simultaneous push and pop allowed when full or empty. Push to an empty FIFO is visible the next cycle.
- Shadow writes: cfg_we_in writes the shadow element at cfg_addr_in in any state. It has no effect on mm_mat_out.
- State machine:
  - RUN: cfg_commit_in (or pending) → DRAIN.
  - DRAIN: vtx_ready_out=0. When inflight==0 and mm_valid_out==0 → SWAP.
  - SWAP, one cycle: active ← shadow as it was before this cycle's write. A same-cycle cfg write still lands in the shadow. Pending cleared → RUN.
  - A commit in DRAIN or SWAP is absorbed, not queued. A commit in the same cycle as SWAP is also absorbed.
- mm_mat_out changes only on the cycle after SWAP. Draining does not wait for the FIFO to empty.

Test Plan:
- Identity pass-through: after reset, push {4,3,2,1} with res_ready_in=1 → one mm_valid_out pulse with mm_vec_out={4,3,2,1}. Model returns the vector → res_data_out={4,3,2,1}, vtx_count_out=1, err_out=0.
- Backpressure and credit: FIFO_DEPTH=8, res_ready_in=0, 12 vertices offered, model latency 3 → exactly 8 issued and vtx_ready_out low. Raise res_ready_in → all 12 emerge in order, vtx_count_out=12.
- Commit with 3 in flight: write shadow diag=2·ONE, pulse commit → no new issue until the 3 results return. Swap follows and mm_mat_out diagonal = 32'h0002_0000 afterwards. Earlier results use identity.
- Simultaneous events: cfg write to element 0 with value 5 in the SWAP cycle → active[0]=old shadow value, shadow[0]=5. Commit pulsed during DRAIN → exactly one SWAP.
- Spurious result: mm_valid_in with inflight==0 → err_out=1 and stays high, FIFO unchanged.
- Async reset mid-stream: assert rst_in between clock edges with 4 in flight → all outputs take reset values immediately and mm_mat_out=identity. Late results after release set err_out.
